mc_main_controller: RTL and testbench
=====================================

// Module: mc_main_controller
// PURPOSE
//  Multi-cycle RISC-V (RV32I subset) main control FSM: sequences fetch/decode/execute/memory/writeback
//  and drives datapath mux selects, write enables, ALU control and the immediate-format select
//  consumed by the immediate extender. Sits between the instruction register fields and the datapath.
// PARAMETERS
//  IMM_I  3'd0  imm_sel code for I-format (lw, I-ALU, jalr)
//  IMM_S  3'd1  imm_sel code for S-format (sw)
//  IMM_J  3'd2  imm_sel code for J-format (jal)
//  IMM_U  3'd3  imm_sel code for U-format (lui)
//  IMM_B  3'd4  imm_sel code for B-format (branches)
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous reset, active low
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7_5    in   1  instr[30]
//  zero        in   1  ALU result == 0
//  neg         in   1  ALU result[31] (signed less-than after sub)
//  pc_write    out  1  PC register enable
//  ir_write    out  1  instruction/old-PC register enable
//  adr_src     out  1  memory address: 0=PC, 1=ALUOut
//  mem_write   out  1  data memory write enable
//  reg_write   out  1  register file write enable
//  result_src  out  2  0=ALUOut, 1=mem data, 2=ALU direct, 3=immediate
//  alu_src_a   out  2  0=PC, 1=old PC, 2=rs1
//  alu_src_b   out  2  0=rs2, 1=imm, 2=const 4
//  alu_ctrl    out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//  imm_sel     out  3  immediate format select (IMM_* codes)
//  illegal_op  out  1  unsupported opcode trapped (see CONFIGURATION)
// BEHAVIOUR
//  - States: BOOT, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB,
//    JAL, JALR, JALR_WB, BRANCH, LUI, HALT. 4-bit state register; rst_n=0 forces BOOT asynchronously.
//  - All outputs default 0 in every state unless listed; BOOT drives all 0, -> FETCH next cycle.
//  - FETCH: adr_src=0, ir_write=1, a=0, b=2, add, result_src=2, pc_write=1 -> DECODE.
//  - DECODE: a=1, b=1, add (branch/jal target into ALUOut). Next by op: 0000011/0100011 MEM_ADR,
//    0110011 EXEC_R, 0010011 EXEC_I, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0110111 LUI.
//  - MEM_ADR: a=2, b=1, add -> MEM_READ (lw) / MEM_WRITE (sw).
//  - MEM_READ: adr_src=1 -> MEM_WB. MEM_WB: result_src=1, reg_write=1 -> FETCH.
//  - MEM_WRITE: adr_src=1, mem_write=1 -> FETCH.
//  - EXEC_R: a=2, b=0, alu_ctrl from funct. EXEC_I: a=2, b=1, funct (sub never) -> both ALU_WB.
//  - ALU_WB: result_src=0, reg_write=1 -> FETCH.
//  - JAL: a=1, b=2, add, result_src=0, pc_write=1 -> ALU_WB (rd <- oldPC+4).
//  - JALR: a=2, b=1, add, result_src=2, pc_write=1 -> JALR_WB: a=1, b=2, add, result_src=2,
//    reg_write=1 -> FETCH.
//  - BRANCH: a=2, b=0, sub, result_src=0; pc_write = taken (Mealy, same cycle). taken: funct3
//    000 zero, 001 !zero, 100 neg, 101 !neg, other 0 -> FETCH.
//  - LUI: result_src=3, reg_write=1 -> FETCH.
//  - alu_ctrl funct decode: funct3 000 add (sub if EXEC_R & funct7_5), 010 slt, 100 xor,
//    110 or, 111 and, others add.
//  - imm_sel: combinational from op in every state (lw/I/jalr IMM_I, sw IMM_S, jal IMM_J,
//    lui IMM_U, branch IMM_B, else IMM_I).
//  - Latency (cycles incl. fetch): lw 5, sw/R/I/jalr 4, jal 4, branch 3, lui 3.
//  - Reset mid-instruction: abandon immediately, all enables low, restart at BOOT.
// CONFIGURATION
//  MC_CTRL_ILLEGAL_TRAP_EN defined: unknown op in DECODE -> HALT; HALT holds illegal_op=1, all
//  enables 0, stays until reset. Undefined: illegal_op tied 0, unknown op DECODE -> FETCH (NOP);
//  HALT unreachable.
// TESTING
//  - Reset, release -> BOOT 1 cycle all outputs 0, then FETCH: pc_write=1, ir_write=1, alu_src_b=2.
//  - lw (op 0000011): 5-cycle sequence; reg_write=1, result_src=1 only in cycle 5; imm_sel=0.
//  - beq, zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; blt with neg=1 -> pc_write=1.
//  - R-type sub (funct3 000, funct7_5=1) -> alu_ctrl=001 in EXEC_R; addi funct7_5=1 -> 000.
//  - jalr: JALR pc_write=1 result_src=2, JALR_WB reg_write=1 a=1 b=2; sw mem_write=1, imm_sel=1.
//  - op 1111111: with macro illegal_op=1 and HALT persists; without, returns to FETCH in 3rd cycle.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the main controller and the multi-cycle datapath:
// instruction fields and ALU flags in, mux selects / enables / ALU control out.
interface mc_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       neg;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [2:0] imm_sel;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7_5, zero, neg,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_ctrl, imm_sel, illegal_op
  );

  modport slave (
    output op, funct3, funct7_5, zero, neg,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_ctrl, imm_sel, illegal_op
  );
endinterface

// File: rtl/mc_main_controller.sv
// Multi-cycle RV32I-subset main control FSM (fetch/decode/execute/memory/writeback).
// Optional feature: MC_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes into a sticky HALT state.
module mc_main_controller #(
  parameter logic [2:0] IMM_I = 3'd0,
  parameter logic [2:0] IMM_S = 3'd1,
  parameter logic [2:0] IMM_J = 3'd2,
  parameter logic [2:0] IMM_U = 3'd3,
  parameter logic [2:0] IMM_B = 3'd4
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_BOOT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_WB   = 4'd12,
    S_BRANCH    = 4'd13,
    S_LUI       = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_OLD_PC = 2'd1;
  localparam logic [1:0] A_RS1    = 2'd2;
  localparam logic [1:0] B_RS2    = 2'd0;
  localparam logic [1:0] B_IMM    = 2'd1;
  localparam logic [1:0] B_FOUR   = 2'd2;

  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;
  localparam logic [1:0] RES_IMM     = 2'd3;

  // Only R-type may turn funct3=000 into a subtract; I-type passes allow_sub=0.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic allow_sub);
    logic [2:0] ctrl;
    case (f3)
      3'b000:  ctrl = allow_sub ? ALU_SUB : ALU_ADD;
      3'b010:  ctrl = ALU_SLT;
      3'b100:  ctrl = ALU_XOR;
      3'b110:  ctrl = ALU_OR;
      3'b111:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    logic taken;
    case (f3)
      3'b000:  taken = z;
      3'b001:  taken = ~z;
      3'b100:  taken = n;
      3'b101:  taken = ~n;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [2:0] alu_ctrl_s;
  logic [2:0] imm_sel_s;
  logic       illegal_op_s;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control outputs; everything idles at 0 unless the state asserts it.
  always_comb begin
    state_next_s = S_BOOT;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = RES_ALU_OUT;
    alu_src_a_s  = A_PC;
    alu_src_b_s  = B_RS2;
    alu_ctrl_s   = ALU_ADD;
    illegal_op_s = 1'b0;
    case (state_r)
      S_BOOT: begin
        state_next_s = S_FETCH;
      end
      S_FETCH: begin
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b1;
        alu_src_a_s  = A_PC;
        alu_src_b_s  = B_FOUR;
        alu_ctrl_s   = ALU_ADD;
        result_src_s = RES_ALU;
        pc_write_s   = 1'b1;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        // Precompute oldPC+imm so branch/jal targets sit in ALUOut.
        alu_src_a_s = A_OLD_PC;
        alu_src_b_s = B_IMM;
        alu_ctrl_s  = ALU_ADD;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next_s = S_MEM_ADR;
          OP_RTYPE:          state_next_s = S_EXEC_R;
          OP_ITYPE:          state_next_s = S_EXEC_I;
          OP_JAL:            state_next_s = S_JAL;
          OP_JALR:           state_next_s = S_JALR;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_LUI:            state_next_s = S_LUI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           state_next_s = S_HALT;
`else
          default:           state_next_s = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_s = A_RS1;
        alu_src_b_s = B_IMM;
        alu_ctrl_s  = ALU_ADD;
        if (bus.op == OP_STORE) begin
          state_next_s = S_MEM_WRITE;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        adr_src_s    = 1'b1;
        state_next_s = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src_s = RES_MEM;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src_s    = 1'b1;
        mem_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_s  = A_RS1;
        alu_src_b_s  = B_RS2;
        alu_ctrl_s   = alu_decode(bus.funct3, bus.funct7_5);
        state_next_s = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_s  = A_RS1;
        alu_src_b_s  = B_IMM;
        alu_ctrl_s   = alu_decode(bus.funct3, 1'b0);
        state_next_s = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src_s = RES_ALU_OUT;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link address.
        alu_src_a_s  = A_OLD_PC;
        alu_src_b_s  = B_FOUR;
        alu_ctrl_s   = ALU_ADD;
        result_src_s = RES_ALU_OUT;
        pc_write_s   = 1'b1;
        state_next_s = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a_s  = A_RS1;
        alu_src_b_s  = B_IMM;
        alu_ctrl_s   = ALU_ADD;
        result_src_s = RES_ALU;
        pc_write_s   = 1'b1;
        state_next_s = S_JALR_WB;
      end
      S_JALR_WB: begin
        alu_src_a_s  = A_OLD_PC;
        alu_src_b_s  = B_FOUR;
        alu_ctrl_s   = ALU_ADD;
        result_src_s = RES_ALU;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = A_RS1;
        alu_src_b_s  = B_RS2;
        alu_ctrl_s   = ALU_SUB;
        result_src_s = RES_ALU_OUT;
        pc_write_s   = branch_taken(bus.funct3, bus.zero, bus.neg);
        state_next_s = S_FETCH;
      end
      S_LUI: begin
        result_src_s = RES_IMM;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_op_s = 1'b1;
        state_next_s = S_HALT;
`else
        state_next_s = S_BOOT;
`endif
      end
      default: begin
        state_next_s = S_BOOT;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_sel_s = IMM_I;
    case (bus.op)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_sel_s = IMM_I;
      OP_STORE:                   imm_sel_s = IMM_S;
      OP_JAL:                     imm_sel_s = IMM_J;
      OP_LUI:                     imm_sel_s = IMM_U;
      OP_BRANCH:                  imm_sel_s = IMM_B;
      default:                    imm_sel_s = IMM_I;
    endcase
  end

  assign bus.pc_write   = pc_write_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.adr_src    = adr_src_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.result_src = result_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_ctrl   = alu_ctrl_s;
  assign bus.imm_sel    = imm_sel_s;
  assign bus.illegal_op = illegal_op_s;

endmodule

// File: tb/tb_mc_main_controller.sv
// Self-checking bench for mc_main_controller: directed cases then random instructions,
// each compared cycle by cycle against a per-instruction-class control sequence model.
module tb_mc_main_controller;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [2:0] imm_sel;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLT = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_count = 0;
  int   total_count = 0;
  ctrl_t exp_q[$];

  mc_ctrl_if bus();

  mc_main_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t observe();
    ctrl_t c;
    c = '{bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write, bus.reg_write,
          bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_sel,
          bus.illegal_op};
    return c;
  endfunction

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'd0;
      7'b0100011: return 3'd1;
      7'b1101111: return 3'd2;
      7'b0110111: return 3'd3;
      7'b1100011: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? SUB : ADD;
      3'b010:  return SLT;
      3'b100:  return XOR;
      3'b110:  return OR;
      3'b111:  return AND;
      default: return ADD;
    endcase
  endfunction

  // Builds one expected cycle; the immediate select is filled in by the model.
  function automatic ctrl_t cyc(input logic pcw, input logic irw, input logic adr,
                                input logic mw, input logic rw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] alu);
    ctrl_t c;
    c = '{pcw, irw, adr, mw, rw, rs, a, b, alu, 3'd0, 1'b0};
    return c;
  endfunction

  // Expected per-cycle controls for one instruction, starting at its fetch cycle.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic n, output bit halts);
    logic taken;
    halts = 1'b0;
    exp_q.delete();
    exp_q.push_back(cyc(1, 1, 0, 0, 0, 2'd2, 2'd0, 2'd2, ADD));
    exp_q.push_back(cyc(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, ADD));
    case (op)
      7'b0000011: begin
        exp_q.push_back(cyc(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ADD));
        exp_q.push_back(cyc(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, ADD));
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, ADD));
      end
      7'b0100011: begin
        exp_q.push_back(cyc(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ADD));
        exp_q.push_back(cyc(0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, ADD));
      end
      7'b0110011: begin
        exp_q.push_back(cyc(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, alu_for(f3, f7)));
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ADD));
      end
      7'b0010011: begin
        exp_q.push_back(cyc(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, alu_for(f3, 1'b0)));
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ADD));
      end
      7'b1101111: begin
        exp_q.push_back(cyc(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, ADD));
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ADD));
      end
      7'b1100111: begin
        exp_q.push_back(cyc(1, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1, ADD));
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd2, 2'd1, 2'd2, ADD));
      end
      7'b1100011: begin
        taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) ||
                (f3 == 3'b100 && n) || (f3 == 3'b101 && !n);
        exp_q.push_back(cyc(taken, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, SUB));
      end
      7'b0110111: begin
        exp_q.push_back(cyc(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, ADD));
      end
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        halts = 1'b1;
`else
        halts = 1'b0;
`endif
      end
    endcase
    foreach (exp_q[i]) exp_q[i].imm_sel = imm_for(op);
  endtask

  task automatic check(input string tag, input ctrl_t expv);
    ctrl_t obs;
    obs = observe();
    total_count++;
    assert (obs === expv) pass_count++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Called #1 after a posedge; leaves the DUT in FETCH at #1 after a posedge.
  task automatic do_reset(input string tag);
    ctrl_t zero_v;
    rst_n = 1'b0;
    zero_v = '0;
    zero_v.imm_sel = imm_for(bus.op);
    @(negedge clk);
    check({tag, "_reset"}, zero_v);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_boot"}, zero_v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic n);
    bit    halts;
    ctrl_t halt_v;
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7_5 = f7;
    bus.zero = z;
    bus.neg = n;
    model(op, f3, f7, z, n, halts);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      @(posedge clk);
      #1;
    end
    if (halts) begin
      halt_v = '0;
      halt_v.illegal_op = 1'b1;
      halt_v.imm_sel = imm_for(op);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("%s_halt%0d", tag, k), halt_v);
        @(posedge clk);
        #1;
      end
      do_reset({tag, "_rec"});
    end
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [6:0] rop;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0110111, 7'b1111111};
    bus.op = 7'd0;
    bus.funct3 = 3'd0;
    bus.funct7_5 = 1'b0;
    bus.zero = 1'b0;
    bus.neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
    run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
    run_instr("blt_t",   7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
    run_instr("bge_nt",  7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
    run_instr("r_sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
    run_instr("jalr",    7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("lui",     7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("r_and",   7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0);

    // Reset two cycles into a load must abandon it at once.
    bus.op = 7'b0000011;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_reset("mid");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rop = 7'($urandom_range(0, 127));
      end else begin
        rop = ops[$urandom_range(0, 8)];
      end
      run_instr($sformatf("rnd%0d", i), rop, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    run_instr("last", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
